// File: rtl/adc_snap_capture.sv
// adc_snap_capture: arm/trigger snapshot engine for the demuxed ADC user interface.
// It stores a burst of valid sample words in an internal buffer. Software reads the
// buffer back through a registered read-first port. The engine also reports which
// sync lane fired the trigger and keeps a saturating overrange count.
module adc_snap_capture #(
    parameter int NUM_CH     = 2,
    parameter int NUM_LANES  = 4,
    parameter int SAMPLE_W   = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int OVR_CNT_W  = 16,
    localparam int WORD_W    = NUM_CH * NUM_LANES * SAMPLE_W,
    localparam int CNT_W     = DEPTH_LOG2 + 1,
    localparam int TL_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                  ctrl_clk_in,
    input  logic                  ctrl_reset,
    input  logic [WORD_W-1:0]     user_data,
    input  logic [NUM_LANES-1:0]  user_sync,
    input  logic [NUM_CH-1:0]     user_outofrange,
    input  logic                  user_data_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [CNT_W-1:0]      capture_len,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WORD_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      words_captured,
    output logic [TL_W-1:0]       trig_lane,
    output logic [OVR_CNT_W-1:0]  ovr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Index of the lowest asserted sync lane (lane 0 is the oldest sample).
    function automatic logic [TL_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] s);
        lowest_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (s[i]) lowest_lane = TL_W'(i);
        end
    endfunction

    // A length of zero, or anything beyond the buffer, means a full-buffer capture.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if (len == '0 || len > CNT_W'(DEPTH)) eff_len = CNT_W'(DEPTH);
        else                                  eff_len = len;
    endfunction

    logic [WORD_W-1:0]     mem [DEPTH];

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [TL_W-1:0]       lane_q, lane_d;
    logic [OVR_CNT_W-1:0]  ovr_q, ovr_d;
    logic [WORD_W-1:0]     rd_data_q;

    logic                  trig_hit;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [CNT_W-1:0]      wcnt_inc;

    // Trigger qualification for the mode latched at arm time; reserved mode acts as immediate.
    always_comb begin
        trig_hit = 1'b0;
        if (user_data_valid) begin
            case (mode_q)
                2'd1:    trig_hit = |user_sync;
                2'd2:    trig_hit = |user_outofrange;
                default: trig_hit = 1'b1;
            endcase
        end
    end

    assign wcnt_inc = wcnt_q + 1'b1;

    // Next-state, capture write strobe and counter updates; abort overrides everything.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        lane_d  = lane_q;
        ovr_d   = ovr_q;
        wr_en   = 1'b0;
        wr_addr = wcnt_q[DEPTH_LOG2-1:0];

        if (state_q != IDLE && user_data_valid && (|user_outofrange) && ovr_q != '1) begin
            ovr_d = ovr_q + 1'b1;
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d = ARMED;
                        mode_d  = trig_mode;
                        len_d   = eff_len(capture_len);
                        wcnt_d  = '0;
                        lane_d  = '0;
                        ovr_d   = '0;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        wcnt_d  = CNT_W'(1);
                        lane_d  = (mode_q == 2'd1) ? lowest_lane(user_sync) : '0;
                        state_d = (len_q == CNT_W'(1)) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (user_data_valid) begin
                        wr_en  = 1'b1;
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc == len_q) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge ctrl_clk_in) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
            lane_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            lane_q  <= lane_d;
            ovr_q   <= ovr_d;
        end
    end

    // Capture buffer write; contents deliberately survive reset.
    always_ff @(posedge ctrl_clk_in) begin
        if (wr_en) mem[wr_addr] <= user_data;
    end

    // Registered read port; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge ctrl_clk_in) begin
        if (ctrl_reset) rd_data_q <= '0;
        else            rd_data_q <= mem[rd_addr];
    end

    assign rd_data        = rd_data_q;
    assign busy           = (state_q == ARMED) || (state_q == CAPTURE);
    assign done           = (state_q == DONE);
    assign words_captured = wcnt_q;
    assign trig_lane      = lane_q;
    assign ovr_count      = ovr_q;

endmodule
